// File: rtl/dibu_pkg.sv
// dibu_pkg: shared constants and types for the DIBU execute unit.
//   - control-word width and bit indices
//   - opcode classes, ALU op codes, flag bit positions
//   - control FSM state encoding
package dibu_pkg;

   localparam int signals_size      = 5;
   localparam int sig_pc_inc        = 0;
   localparam int sig_mar_w_en      = 1;
   localparam int sig_reg_rw        = 2;
   localparam int sig_reg_select_in = 3;
   localparam int sig_flags_w_en    = 4;

   // opcode[4:3] == 2'b00 selects the ALU class; opcode[2:0] is then the ALU op
   localparam logic [1:0] opc_alu_class = 2'b00;
   localparam logic [4:0] opc_movi      = 5'b01000;
   localparam logic [4:0] opc_halt      = 5'b11111;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sub = 3'b001,
      alu_and = 3'b010,
      alu_or  = 3'b011,
      alu_xor = 3'b100,
      alu_not = 3'b101,
      alu_shl = 3'b110,
      alu_cmp = 3'b111
   } alu_op_e;

   localparam int flag_z = 0;
   localparam int flag_c = 1;
   localparam int flag_n = 2;
   localparam int flag_v = 3;

   typedef enum logic [1:0] {
      st_fetch = 2'b00,
      st_read  = 2'b01,
      st_exec  = 2'b10,
      st_halt  = 2'b11
   } state_e;

endpackage

// File: rtl/dibu_exec_unit_memory_bank.sv
// memory_bank: simple dual-port code memory.
//   clk   : write clock
//   we    : synchronous write enable
//   waddr : write address, wdata : write data
//   raddr : read address, rdata : combinational read of mem[raddr]
// The consumer registers rdata; because the write lands at the same edge,
// a same-address collision returns the old word (read-first).
// Contents are deliberately not reset.
module memory_bank #(
   parameter int DW = 16,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dibu_exec_unit.sv
// dibu_exec_unit: fetch/execute core of the DIBU processor.
//   clk, rst_n          : clock, async active-low reset
//   prog_we/addr/data   : code-memory program-load port
//   reg_a, reg_b        : operands from external register bank (regs ra, rb)
//   ra, rb, rd          : register indices decoded from ir
//   reg_we, reg_wdata   : register-bank write strobe and data
//   signals             : control word {flags_w_en, reg_select_in, reg_rw, mar_w_en, pc_inc}
//   pc, ir, flags       : architectural state
//   halted              : high once HALT has executed
// Strobe semantics: reg_we is a single-cycle strobe asserted combinationally
// in EXEC; the bank captures rd/reg_wdata on the rising edge closing that
// cycle. There is no backpressure. The FSM state is visible as `state`.
module dibu_exec_unit
   import dibu_pkg::*;
#(
   parameter int CODE_AW = 9,
   parameter int CODE_DW = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    prog_we,
   input  logic [CODE_AW-1:0]      prog_addr,
   input  logic [CODE_DW-1:0]      prog_data,
   input  logic [7:0]              reg_a,
   input  logic [7:0]              reg_b,
   output logic [2:0]              ra,
   output logic [2:0]              rb,
   output logic [2:0]              rd,
   output logic                    reg_we,
   output logic [7:0]              reg_wdata,
   output logic [signals_size-1:0] signals,
   output logic [CODE_AW-1:0]      pc,
   output logic [CODE_DW-1:0]      ir,
   output logic [7:0]              flags,
   output logic                    halted
);

   state_e             state, state_next;
   logic [CODE_AW-1:0] mar;
   logic [CODE_DW-1:0] mem_rdata;

   logic [4:0] opcode;
   logic [2:0] aluop;
   logic [7:0] imm;
   logic [7:0] alu_out;
   logic [3:0] alu_flags;
   logic [8:0] sum9;
   logic [8:0] diff9;

   assign opcode = ir[15:11];
   assign aluop  = ir[13:11];
   assign imm    = ir[7:0];
   assign ra     = ir[5:3];
   assign rb     = ir[2:0];
   assign rd     = ir[10:8];

   memory_bank #(.DW(CODE_DW), .AW(CODE_AW)) u_code_mem (
      .clk   (clk),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (mar),
      .rdata (mem_rdata)
   );

   // ALU: 9-bit add/sub so bit 8 is carry (ADD) or borrow (SUB/CMP)
   always_comb begin
      sum9      = {1'b0, reg_a} + {1'b0, reg_b};
      diff9     = {1'b0, reg_a} - {1'b0, reg_b};
      alu_out   = 8'h00;
      alu_flags = 4'h0;
      case (aluop)
         alu_add: begin
            alu_out           = sum9[7:0];
            alu_flags[flag_c] = sum9[8];
            alu_flags[flag_v] = (reg_a[7] == reg_b[7]) && (sum9[7] != reg_a[7]);
         end
         alu_sub, alu_cmp: begin
            alu_out           = diff9[7:0];
            alu_flags[flag_c] = diff9[8];
            alu_flags[flag_v] = (reg_a[7] != reg_b[7]) && (diff9[7] != reg_a[7]);
         end
         alu_and: alu_out = reg_a & reg_b;
         alu_or:  alu_out = reg_a | reg_b;
         alu_xor: alu_out = reg_a ^ reg_b;
         alu_not: alu_out = ~reg_a;
         alu_shl: begin
            alu_out           = {reg_a[6:0], 1'b0};
            alu_flags[flag_c] = reg_a[7];
         end
         default: alu_out = 8'h00;
      endcase
      alu_flags[flag_z] = (alu_out == 8'h00);
      alu_flags[flag_n] = alu_out[7];
   end

   // Control FSM: next state and control word
   always_comb begin
      state_next = state;
      signals    = '0;
      case (state)
         st_fetch: begin
            signals[sig_mar_w_en] = 1'b1;
            state_next            = st_read;
         end
         st_read: begin
            signals[sig_pc_inc] = 1'b1;
            state_next          = st_exec;
         end
         st_exec: begin
            state_next = st_fetch;
            if (opcode[4:3] == opc_alu_class) begin
               signals[sig_flags_w_en] = 1'b1;
               signals[sig_reg_rw]     = (aluop != alu_cmp);
            end else if (opcode == opc_movi) begin
               signals[sig_reg_rw]        = 1'b1;
               signals[sig_reg_select_in] = 1'b1;
            end else if (opcode == opc_halt) begin
               state_next = st_halt;
            end
         end
         st_halt: state_next = st_halt;
         default: state_next = st_fetch;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= st_fetch;
         pc    <= '0;
         mar   <= '0;
         ir    <= '0;
         flags <= 8'h00;
      end else begin
         state <= state_next;
         if (signals[sig_mar_w_en])   mar   <= pc;
         if (signals[sig_pc_inc])     pc    <= pc + 1'b1;
         if (state == st_read)        ir    <= mem_rdata;
         if (signals[sig_flags_w_en]) flags <= {4'h0, alu_flags};
      end
   end

   assign reg_we    = signals[sig_reg_rw];
   assign reg_wdata = signals[sig_reg_select_in] ? imm : alu_out;
   assign halted    = (state == st_halt);

endmodule

// File: tb/tb_dibu_exec_unit.sv
module tb_dibu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        prog_we;
   logic [8:0]  prog_addr;
   logic [15:0] prog_data;
   logic [7:0]  reg_a;
   logic [7:0]  reg_b;
   logic [2:0]  ra, rb, rd;
   logic        reg_we;
   logic [7:0]  reg_wdata;
   logic [4:0]  signals;
   logic [8:0]  pc;
   logic [15:0] ir;
   logic [7:0]  flags;
   logic        halted;

   int total = 0;
   int bad   = 0;

   // expected register writes: {rd, wdata}
   logic [10:0] exp_q[$];

   dibu_exec_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .reg_a     (reg_a),
      .reg_b     (reg_b),
      .ra        (ra),
      .rb        (rb),
      .rd        (rd),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .signals   (signals),
      .pc        (pc),
      .ir        (ir),
      .flags     (flags),
      .halted    (halted)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // directed program and hand-computed results (instr 1..9 use ta/tb)
   logic [15:0] prog_a [0:10] = '{16'h412A, 16'h021C, 16'h0B1C, 16'h3C1C, 16'h151C,
                                  16'h2E1C, 16'h371C, 16'h181C, 16'h211C, 16'h4800,
                                  16'hF800};
   logic [7:0] ta [1:9] = '{8'hFF, 8'h80, 8'h05, 8'hF0, 8'h00, 8'h81, 8'h0F, 8'h55, 8'h00};
   logic [7:0] tb [1:9] = '{8'h01, 8'h01, 8'h05, 8'h3C, 8'h00, 8'h00, 8'hA0, 8'h55, 8'h00};
   logic [7:0] tf [1:9] = '{8'h03, 8'h08, 8'h01, 8'h00, 8'h04, 8'h02, 8'h04, 8'h01, 8'h01};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // driver: load one code word per cycle
   task automatic prog_word(input int addr, input logic [15:0] data);
      prog_we   = 1'b1;
      prog_addr = addr[8:0];
      prog_data = data;
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   // scoreboard monitor: every write strobe must match the next expected write
   always @(negedge clk) begin
      logic [10:0] e;
      if (reg_we) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write actual rd=%0d wdata=%h required none", rd, reg_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({rd, reg_wdata} !== e) begin
               bad++;
               $display("FAIL reg_write actual rd=%0d wdata=%h required rd=%0d wdata=%h",
                        rd, reg_wdata, e[10:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      reg_a = 8'h00; reg_b = 8'h00;
      repeat (2) @(negedge clk);

      // ---- directed program: MOVI + every ALU op + NOP + HALT ----
      for (int i = 0; i < 11; i++) prog_word(i, prog_a[i]);
      exp_q.push_back({3'd1, 8'h2A});
      exp_q.push_back({3'd2, 8'h00});
      exp_q.push_back({3'd3, 8'h7F});
      exp_q.push_back({3'd5, 8'h30});
      exp_q.push_back({3'd6, 8'hFF});
      exp_q.push_back({3'd7, 8'h02});
      exp_q.push_back({3'd0, 8'hAF});
      exp_q.push_back({3'd1, 8'h00});
      check("reset_pc", 32'(pc), 32'd0);
      check("reset_ir", 32'(ir), 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      check("reset_reg_we", 32'(reg_we), 32'd0);
      check("reset_halted", 32'(halted), 32'd0);

      rst_n = 1'b1;
      #1 check("cyc1_signals", 32'(signals), 32'h02);
      @(negedge clk); check("cyc2_signals", 32'(signals), 32'h01);
      @(negedge clk);
      check("cyc3_signals", 32'(signals), 32'h0C);
      check("cyc3_rd", 32'(rd), 32'd1);
      check("cyc3_wdata", 32'(reg_wdata), 32'h2A);
      @(negedge clk);
      check("movi_pc", 32'(pc), 32'd1);
      check("movi_flags", 32'(flags), 32'd0);
      for (int k = 1; k <= 9; k++) begin
         reg_a = ta[k];
         reg_b = tb[k];
         repeat (3) @(negedge clk);
         check($sformatf("flags_instr%0d", k), 32'(flags), 32'(tf[k]));
      end
      repeat (3) @(negedge clk);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_signals", 32'(signals), 32'd0);
      check("halt_pc", 32'(pc), 32'd11);
      repeat (4) @(negedge clk);
      check("halt_pc_hold", 32'(pc), 32'd11);
      check("halt_signals_hold", 32'(signals), 32'd0);

      // ---- PC wrap over 512 NOPs ----
      rst_n = 1'b0;
      #1;
      check("rst2_halted", 32'(halted), 32'd0);
      check("rst2_flags", 32'(flags), 32'd0);
      check("rst2_pc", 32'(pc), 32'd0);
      check("rst2_ir", 32'(ir), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 512; i++) prog_word(i, 16'h4800);
      rst_n = 1'b1;
      repeat (1534) @(posedge clk);
      #1 check("wrap_pc_511", 32'(pc), 32'd511);
      repeat (2) @(posedge clk);
      #1 check("wrap_pc_0", 32'(pc), 32'd0);

      // ---- HALT at address 3 ----
      rst_n = 1'b0;
      @(negedge clk);
      prog_word(3, 16'hF800);
      rst_n = 1'b1;
      repeat (11) @(posedge clk);
      #1 check("halt3_not_yet", 32'(halted), 32'd0);
      @(posedge clk);
      #1;
      check("halt3_halted", 32'(halted), 32'd1);
      check("halt3_pc", 32'(pc), 32'd4);
      check("halt3_signals", 32'(signals), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("halt3_pc_hold", 32'(pc), 32'd4);
      check("halt3_signals_hold", 32'(signals), 32'd0);

      // ---- async reset during EXEC of an ADD ----
      rst_n = 1'b0;
      @(negedge clk);
      prog_word(0, 16'h021C);
      prog_word(1, 16'h021C);
      reg_a = 8'hFF;
      reg_b = 8'h01;
      exp_q.push_back({3'd2, 8'h00});
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("abort_in_exec", 32'(signals), 32'h14);
      check("abort_flags_before", 32'(flags), 32'h03);
      rst_n = 1'b0;
      #1;
      check("abort_reg_we", 32'(reg_we), 32'd0);
      check("abort_flags", 32'(flags), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);

      // ---- read/write collision on the address being read ----
      @(negedge clk);
      prog_word(0, 16'h4411);
      prog_word(1, 16'hF800);
      exp_q.push_back({3'd4, 8'h11});
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      prog_we = 1'b1; prog_addr = 9'd0; prog_data = 16'h4499;
      @(posedge clk);
      #1;
      prog_we = 1'b0;
      check("collision_ir_old", 32'(ir), 32'h4411);
      repeat (5) @(posedge clk);
      #1 check("collision_halted", 32'(halted), 32'd1);
      rst_n = 1'b0;
      exp_q.push_back({3'd4, 8'h99});
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("collision_ir_new", 32'(ir), 32'h4499);
      repeat (6) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
